// File: rtl/i2c_master_if.sv
// Command/status and open-drain bus signals for the single-byte I2C master.
// The master modport is used by i2c_master; the slave modport is for whatever drives the commands.
interface i2c_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  start, addr, rw, wdata, sda_in,
    output rdata, busy, done, ack_err, scl_out, sda_out
  );

  modport slave (
    output start, addr, rw, wdata, sda_in,
    input  rdata, busy, done, ack_err, scl_out, sda_out
  );
endinterface

// File: rtl/i2c_master.sv
// Single-master I2C initiator: one START, address+R/W, one data byte, ACK handling, STOP per command.
// SCL is built from QDIV-cycle quarter periods; both bus drives come straight from flops.
module i2c_master #(
  parameter int QDIV = 4
) (
  input logic          clk,
  input logic          n_rst,
  i2c_master_if.master bus
);

  localparam int CW = $clog2(QDIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_NACK, S_STOP, S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    q_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q, wdata_q, rdata_q;
  logic          rw_q, sample_q, ack_err_q, busy_q, done_q;
  logic          scl_q, sda_q, sync1_q, sync2_q;
  logic          active, wrap;

  always_comb begin
    active = (state_q != S_IDLE) && (state_q != S_DONE);
    wrap   = active && (qcnt_q == CW'(QDIV - 1));
    qcnt_d = '0;
    if (active && !wrap) qcnt_d = qcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      q_q       <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      sample_q  <= 1'b1;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      qcnt_q  <= qcnt_d;
      done_q  <= 1'b0;
      sync1_q <= bus.sda_in;
      sync2_q <= sync1_q;

      // First cycle of q3: SCL has been high a full quarter, synchronizer has settled
      if (active && qcnt_q == '0 && q_q == 2'd3) begin
        sample_q <= sync2_q;
        if (state_q == S_READ) rdata_q <= {rdata_q[6:0], sync2_q};
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shift_q   <= {bus.addr, bus.rw};
            rw_q      <= bus.rw;
            wdata_q   <= bus.wdata;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b1;
            sda_q     <= 1'b0;
            q_q       <= '0;
            state_q   <= S_START;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (wrap) begin
            q_q <= q_q + 2'd1;
            if (q_q == 2'd1) scl_q <= 1'b1;
            if (state_q == S_STOP && q_q == 2'd2) sda_q <= 1'b1;
            // Phase boundary: later assignments here override the generic quarter updates
            if ((state_q == S_START) ? (q_q == 2'd1) : (q_q == 2'd3)) begin
              q_q   <= '0;
              scl_q <= 1'b0;
              case (state_q)
                S_START: begin
                  sda_q    <= shift_q[7];
                  shift_q  <= {shift_q[6:0], 1'b0};
                  bitcnt_q <= 3'd7;
                  state_q  <= S_ADDR;
                end
                S_ADDR, S_WRITE: begin
                  if (bitcnt_q == 3'd0) begin
                    sda_q   <= 1'b1;
                    state_q <= (state_q == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                  end else begin
                    bitcnt_q <= bitcnt_q - 3'd1;
                    sda_q    <= shift_q[7];
                    shift_q  <= {shift_q[6:0], 1'b0};
                  end
                end
                S_ADDR_ACK: begin
                  bitcnt_q <= 3'd7;
                  if (sample_q) begin
                    ack_err_q <= 1'b1;
                    sda_q     <= 1'b0;
                    state_q   <= S_STOP;
                  end else if (rw_q) begin
                    sda_q   <= 1'b1;
                    state_q <= S_READ;
                  end else begin
                    sda_q   <= wdata_q[7];
                    shift_q <= {wdata_q[6:0], 1'b0};
                    state_q <= S_WRITE;
                  end
                end
                S_WRITE_ACK: begin
                  if (sample_q) ack_err_q <= 1'b1;
                  sda_q   <= 1'b0;
                  state_q <= S_STOP;
                end
                S_READ: begin
                  sda_q <= 1'b1;
                  if (bitcnt_q == 3'd0) state_q <= S_READ_NACK;
                  else bitcnt_q <= bitcnt_q - 3'd1;
                end
                S_READ_NACK: begin
                  sda_q   <= 1'b0;
                  state_q <= S_STOP;
                end
                S_STOP: begin
                  scl_q   <= 1'b1;
                  sda_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.scl_out = scl_q;
  assign bus.sda_out = sda_q;

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-master I2C bus initiator that pairs with the team's I2C slave for loopback and system test. Each command runs one complete single-byte transaction: START, 7-bit address plus R/W, one data byte (write or read), ACK/NACK handling, then STOP. SCL is generated from clk by a programmable quarter-period divider. Both bus lines are open-drain style: 1 releases the line, 0 drives it low.

Parameters:
QDIV, 4, clk cycles per SCL quarter-period. Legal range is >= 4; the SCL period is 4*QDIV.

Ports:
clk  input  1  system clock
n_rst  input  1  reset; synchronous, active-low
start  input  1  command strobe; sampled only in IDLE
addr  input  7  target slave address, latched at accept
rw  input  1  0 = write wdata, 1 = read one byte; latched at accept
wdata  input  8  write byte, latched at accept
rdata  output  8  received byte; valid when done=1 and rw was 1
busy  output  1  high from the cycle after accept until the done cycle
done  output  1  one-cycle completion pulse
ack_err  output  1  a NACK was seen in this transaction; valid with done
scl_out  output  1  SCL drive (1 = release, 0 = pull low)
sda_out  output  1  SDA drive (1 = release, 0 = pull low)
sda_in  input  1  raw SDA bus level; synchronized internally with 2 flops

Behaviour:
- Reset (synchronous, n_rst=0 at a clk edge): scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, rdata=8'h00, state=IDLE, counters cleared. Reset mid-transaction releases the bus immediately and generates no STOP.
- Quarter counter: counts 0..QDIV-1 and wraps. Each wrap advances the quarter index q (0..3) within the current phase.
- IDLE: scl_out=1, sda_out=1. When start=1, latch {addr, rw, wdata}, clear ack_err, and enter START. Any start while busy=1 is ignored.
- START: 2 quarters with scl_out=1, sda_out=0.
- Bit slot (4 quarters):
  - q0, q1: scl_out=0; sda_out is updated on entry to q0.
  - q2, q3: scl_out=1.
  - The synchronized SDA is sampled on the first cycle of q3.
- ADDR: 8 slots, shifting {addr, rw} MSB first.
- ADDR_ACK: 1 slot with sda_out=1.
  - Sampled 1 (NACK): set ack_err and go to STOP.
  - Sampled 0: go to WRITE if rw=0, READ if rw=1.
- WRITE: 8 slots, wdata MSB first. WRITE_ACK: 1 slot with sda_out released; a sampled 1 sets ack_err. Then STOP.
- READ: 8 slots with sda_out=1; the sampled bits shift into rdata MSB first. READ_NACK: 1 slot with sda_out=1 (master NACK ends the read). Then STOP.
- STOP: 4 quarters.
  - q0, q1: scl_out=0, sda_out=0.
  - q2: scl_out=1, sda_out=0.
  - q3: scl_out=1, sda_out=1 (SDA rising while SCL high).
- DONE: 1 cycle with done=1, busy=0, rdata and ack_err stable. Return to IDLE; a new start is accepted in the following cycle.
- Latency from the accept edge to done:
  - Full transaction: (2 + 36 + 36 + 4) * QDIV = 78*QDIV cycles.
  - Address NACK: 42*QDIV cycles.
- The SDA sample point includes the 2-cycle synchronizer delay, which is why QDIV >= 4 is required.
- Not supported: clock stretching (scl_in is not monitored), arbitration, repeated START, and multi-byte transfers.
- Glitch-free outputs: scl_out and sda_out are driven directly from flops. SDA never changes while scl_out=1, except at START and STOP.
- ack_err holds its value until the next accepted start.

Test Plan:
- Reset: hold n_rst=0 for 3 clk -> scl_out=1, sda_out=1, busy=0, done=0, rdata=8'h00.
- Write: QDIV=4, addr=7'h3C, rw=0, wdata=8'hA5, bench ACKs both bytes -> SDA bit sequence 0111100_0 then 10100101 observed at SCL rises; STOP seen; done pulses 312 cycles after accept; ack_err=0.
- Read: addr=7'h3C, rw=1, bench ACKs address and drives 8'h5A -> rdata=8'h5A at done; master releases SDA (NACK) on the 9th read slot; ack_err=0.
- Address NACK: bench leaves SDA high -> no data slots, STOP follows immediately; done at 168 cycles (QDIV=4); ack_err=1.
- Busy protection: pulse start mid-transaction with different addr -> ignored; the bus trace matches the original command exactly.
- Reset mid-transfer: n_rst=0 during the 3rd ADDR slot -> next edge scl_out=1, sda_out=1, busy=0; a new start after release completes normally with a correct trace.
